cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single result-writeback bus (CDB) that writes ROB entries and wakes reservation stations.
- Serves N_REQ execution-side requesters (default: 0 = ALU, 1 = branch unit, 2 = load/store buffer).
- Each requester feeds a 2-entry buffer. One head per cycle is granted by round-robin and driven onto a registered CDB.
- Sits between the execution units and the ROB/RS. A ROB-commit misprediction flush clears it.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- Q_WIDTH, 4, ROB index width.
- DATA_WIDTH, 32, result value and pc width.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset; asynchronous, active-low.
- rdy_in  input  1  global ready; low = freeze.
- flush_in  input  1  misprediction flush from ROB commit.
- req_valid  input  N_REQ  requester i offers a result.
- req_ready  output  N_REQ  requester i's buffer can accept.
- req_rob_pos  input  N_REQ*Q_WIDTH  target ROB slot; slice i = [i*Q_WIDTH +: Q_WIDTH].
- req_value  input  N_REQ*DATA_WIDTH  result value.
- req_pc  input  N_REQ*DATA_WIDTH  resolved next pc (branch); don't-care for others.
- cdb_valid  output  1  CDB carries a result this cycle.
- cdb_rob_pos  output  Q_WIDTH  ROB slot written.
- cdb_value  output  DATA_WIDTH  result.
- cdb_pc  output  DATA_WIDTH  resolved pc.
- cdb_src  output  $clog2(N_REQ)  index of granted requester.

Behaviour:
- Reset (rst_in=0, async):
  - buffers empty; rr pointer = 0.
  - cdb_valid=0; cdb_rob_pos=0; cdb_value=0; cdb_pc=0; cdb_src=0.
  - req_ready=0 while reset is asserted.
  - Reset mid-operation drops all buffered results.
- Accept:
  - req_ready[i] = rdy_in && !flush_in && (count_i < 2).
  - Push on req_valid[i] && req_ready[i] at the clock edge.
  - Requesters hold payload stable until accepted.
- Arbitration (combinational over buffer heads in cycle T):
  - Grant the first non-empty buffer at index rr, rr+1, … modulo N_REQ. Wrap is explicit, not power-of-2.
  - On grant g: pop head g; register it onto the CDB for cycle T+1; rr <= (g+1 == N_REQ) ? 0 : g+1.
  - No non-empty buffer: cdb_valid <= 0, rr unchanged.
- Latency: accepted at edge ending cycle T, earliest on CDB during cycle T+2. No buffer bypass.
- Simultaneous push and pop on the same buffer: legal, count unchanged, FIFO order preserved. With count 2 (full), req_ready is 0 regardless of the pop that cycle (no ready-on-pop).
- Throughput: 1 result/cycle total. A requester with a full buffer is served at least once every N_REQ cycles.
- cdb_valid is a 1-cycle pulse per granted entry. Back-to-back grants give consecutive pulses.
- rdy_in=0:
  - all state and outputs hold, including cdb_valid; ROB/RS also ignore that cycle.
  - no pushes, no pops; flush_in ignored.
- flush_in=1 with rdy_in=1 (synchronous):
  - all buffers emptied; rr <= 0; cdb_valid <= 0 next cycle.
  - no accepts that cycle.
  - Flush beats any same-cycle grant; the grant is discarded.
- Duplicate rob_pos from different requesters is not checked (the ROB guarantees uniqueness).

Optional Feature:
- Macro CDB_FIXED_PRIO_EN.
- Defined:
  - buffer N_REQ-1 (load/store buffer) wins whenever it is non-empty.
  - otherwise round-robin among 0..N_REQ-2.
  - rr advances only on round-robin grants.
  - Starvation of the others is accepted by design.
- Undefined: pure round-robin over all N_REQ, as above.

Decomposition:
- Package cdb_pkg:
  - CDB_Q_WIDTH=4, CDB_DATA_WIDTH=32, CDB_N_REQ=3.
  - requester index constants REQ_ALU=0, REQ_BR=1, REQ_SLB=2.
  - packed entry type cdb_entry_t {rob_pos, value, pc}.
- Sub-module cdb_req_buf:
  - 2-entry FIFO, one instance per requester.
  - ports: push, pop, flush, entry in/out, count/empty/full.
  - same reset and rdy_in rules.
- Arbiter, rr pointer and output register live in the top.

Test Plan:
- Reset: hold rst_in=0 mid-traffic with 2 entries buffered → cdb_valid=0 immediately, req_ready=0. Release → req_ready=3'b111, nothing replayed.
- Single latency: ALU pushes rob_pos=5, value=32'hDEADBEEF at edge T → cdb_valid=1, cdb_rob_pos=5, cdb_value=DEADBEEF, cdb_src=0 in cycle T+2 only.
- Round-robin: all three push one entry each cycle for 4 cycles → cdb_src sequence 0,1,2,0,1,2,…; no requester waits over 3 cycles.
- Full buffer: SLB pushes 3 consecutive cycles with no grant (rdy_in=0 after pushes) → req_ready[2]=0 once count=2. Third push stalls until a pop.
- Flush: 2 entries in each buffer, flush_in=1 for one cycle → next cycle cdb_valid=0, all req_ready=1, rr=0, and a push in the flush cycle is dropped.
- Stall: rdy_in=0 for 5 cycles while cdb_valid=1 with rob_pos=7 → outputs frozen at 7. Resume → next grant proceeds normally. With CDB_FIXED_PRIO_EN, SLB and ALU both non-empty → cdb_src=2 first.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared constants and types for the CDB writeback arbiter.
//   CDB_Q_WIDTH / CDB_DATA_WIDTH / CDB_N_REQ : default build widths
//   REQ_ALU / REQ_BR / REQ_SLB               : requester slot indices
//   cdb_entry_t                              : one buffered result {rob_pos, value, pc}
//   rr_wrap()                                : single-step modulo wrap for pointer math
package cdb_pkg;

  localparam int CDB_Q_WIDTH    = 4;
  localparam int CDB_DATA_WIDTH = 32;
  localparam int CDB_N_REQ      = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_BR  = 1;
  localparam int REQ_SLB = 2;

  typedef struct packed {
    logic [CDB_Q_WIDTH-1:0]    rob_pos;
    logic [CDB_DATA_WIDTH-1:0] value;
    logic [CDB_DATA_WIDTH-1:0] pc;
  } cdb_entry_t;

  // Callers guarantee idx < 2*n, so one subtraction is enough; n need not be a power of two.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cdb_req_buf.sv
// cdb_req_buf: 2-entry FIFO holding results from one execution-side requester.
// Ports:
//   clk_in, rst_in : clock, async active-low reset (empties the buffer)
//   en             : global ready; low freezes all state, push/pop/flush ignored
//   flush          : synchronous clear (when en), beats push and pop
//   push, din      : enqueue din (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   head           : oldest entry
//   count          : occupancy 0..2
//   empty, full    : occupancy flags
module cdb_req_buf
  import cdb_pkg::*;
#(
  parameter int W = $bits(cdb_entry_t)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign head    = slot0;
  assign do_push = en && !flush && push && !full;
  assign do_pop  = en && !flush && pop && !empty;

  // slot0 is always the head; a pop shifts slot1 down.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (en) begin
      if (flush) begin
        count <= 2'd0;
      end else begin
        case ({do_push, do_pop})
          2'b10: begin
            if (empty) slot0 <= din;
            else       slot1 <= din;
            count <= count + 2'd1;
          end
          2'b01: begin
            slot0 <= slot1;
            count <= count - 2'd1;
          end
          2'b11: begin
            // Push is blocked when full, so simultaneous push/pop only happens at count 1.
            slot0 <= din;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single registered result bus (CDB) among N_REQ
// execution-side requesters (default 0 = ALU, 1 = branch, 2 = load/store buffer).
// Each requester feeds a 2-entry buffer; one head per cycle is granted and
// registered onto the CDB, so an accepted result is visible two cycles later.
// Build option: define CDB_FIXED_PRIO_EN to give requester N_REQ-1 absolute
// priority, with round-robin among the remaining requesters.
// Ports:
//   clk_in, rst_in         : clock, async active-low reset
//   rdy_in                 : global ready; low freezes everything
//   flush_in               : misprediction flush from ROB commit
//   req_valid / req_ready  : per-requester handshake
//   req_rob_pos/value/pc   : per-requester payload, slice i at [i*W +: W]
//   cdb_valid/rob_pos/value/pc/src : registered CDB outputs
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter  int N_REQ      = CDB_N_REQ,
  parameter  int Q_WIDTH    = CDB_Q_WIDTH,
  parameter  int DATA_WIDTH = CDB_DATA_WIDTH,
  localparam int SRC_W      = $clog2(N_REQ),
  localparam int ENTRY_W    = Q_WIDTH + 2 * DATA_WIDTH
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush_in,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*Q_WIDTH-1:0]    req_rob_pos,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_value,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_pc,
  output logic                        cdb_valid,
  output logic [Q_WIDTH-1:0]          cdb_rob_pos,
  output logic [DATA_WIDTH-1:0]       cdb_value,
  output logic [DATA_WIDTH-1:0]       cdb_pc,
  output logic [SRC_W-1:0]            cdb_src
);

  logic [N_REQ-1:0]   empty;
  logic [N_REQ-1:0]   full;
  logic [N_REQ-1:0]   push;
  logic [N_REQ-1:0]   pop;
  logic [1:0]         count [N_REQ];
  logic [ENTRY_W-1:0] din   [N_REQ];
  logic [ENTRY_W-1:0] head  [N_REQ];

  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   rr;
  logic [SRC_W-1:0]   rr_next;
  logic [SRC_W-1:0]   scan_idx;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign din[i] = {req_rob_pos[i*Q_WIDTH +: Q_WIDTH],
                     req_value[i*DATA_WIDTH +: DATA_WIDTH],
                     req_pc[i*DATA_WIDTH +: DATA_WIDTH]};

    // Ready is not raised by a same-cycle pop, and is held low during reset.
    assign req_ready[i] = rst_in && rdy_in && !flush_in && !full[i];
    assign push[i]      = req_valid[i] && req_ready[i];

    cdb_req_buf #(.W(ENTRY_W)) u_buf (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .en     (rdy_in),
      .flush  (flush_in),
      .push   (push[i]),
      .pop    (pop[i]),
      .din    (din[i]),
      .head   (head[i]),
      .count  (count[i]),
      .empty  (empty[i]),
      .full   (full[i])
    );

    always_comb begin
      if (rst_in) begin
        assert (full[i] == (count[i] == 2'd2) && empty[i] == (count[i] == 2'd0));
      end
    end
  end

  // Grant scan over buffer heads starting at rr. With fixed priority the last
  // requester preempts, and rr only ranges over the first N_REQ-1 requesters.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_next     = rr;
    scan_idx    = '0;
`ifdef CDB_FIXED_PRIO_EN
    if (!empty[N_REQ-1]) begin
      grant_valid = 1'b1;
      grant_idx   = SRC_W'(N_REQ - 1);
    end else begin
      for (int k = 0; k < N_REQ - 1; k++) begin
        scan_idx = SRC_W'(rr_wrap(int'(rr) + k, N_REQ - 1));
        if (!grant_valid && !empty[scan_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = scan_idx;
          rr_next     = SRC_W'(rr_wrap(int'(scan_idx) + 1, N_REQ - 1));
        end
      end
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = SRC_W'(rr_wrap(int'(rr) + k, N_REQ));
      if (!grant_valid && !empty[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
        rr_next     = SRC_W'(rr_wrap(int'(scan_idx) + 1, N_REQ));
      end
    end
`endif
  end

  // The buffer itself ignores pop while frozen or flushing.
  always_comb begin
    pop = '0;
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr          <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_pos <= '0;
      cdb_value   <= '0;
      cdb_pc      <= '0;
      cdb_src     <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        rr        <= '0;
        cdb_valid <= 1'b0;
      end else if (grant_valid) begin
        rr        <= rr_next;
        cdb_valid <= 1'b1;
        {cdb_rob_pos, cdb_value, cdb_pc} <= head[grant_idx];
        cdb_src   <= grant_idx;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [11:0] req_rob_pos = '0;
  logic [95:0] req_value = '0;
  logic [95:0] req_pc = '0;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_value;
  logic [31:0] cdb_pc;
  logic [1:0]  cdb_src;

  cdb_arbiter dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .flush_in    (flush_in),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rob_pos (req_rob_pos),
    .req_value   (req_value),
    .req_pc      (req_pc),
    .cdb_valid   (cdb_valid),
    .cdb_rob_pos (cdb_rob_pos),
    .cdb_value   (cdb_value),
    .cdb_pc      (cdb_pc),
    .cdb_src     (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] value;
    logic [31:0] pc;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per requester, a rotating start index, and the last bus word.
  ent_t mq[3][$];
  int   m_rr = 0;
  logic m_valid = 1'b0;
  ent_t m_out = '0;
  int   m_src = 0;
  logic [2:0] m_acc = '0;

  logic [2:0] offer = '0;
  ent_t off_ent[3];

  function automatic ent_t new_ent();
    ent_t e;
    e.rob   = 4'($urandom_range(0, 15));
    e.value = $urandom;
    e.pc    = $urandom;
    return e;
  endfunction

  function automatic logic [2:0] m_ready();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = rst_in && rdy_in && !flush_in && (mq[i].size() < 2);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    m_rr = 0;
    m_valid = 1'b0;
    m_out = '0;
    m_src = 0;
    m_acc = '0;
  endtask

  task automatic model_step();
    logic [2:0] rd;
    int g;
    ent_t e;
    m_acc = '0;
    if (!rst_in || !rdy_in) return;
    if (flush_in) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      m_rr = 0;
      m_valid = 1'b0;
      return;
    end
    rd = m_ready();
    g = -1;
`ifdef CDB_FIXED_PRIO_EN
    if (mq[2].size() > 0) g = 2;
    else begin
      for (int k = 0; k < 2; k++) begin
        int idx = (m_rr + k) % 2;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g >= 0) m_rr = (g + 1) % 2;
    end
`else
    for (int k = 0; k < 3; k++) begin
      int idx = (m_rr + k) % 3;
      if (g < 0 && mq[idx].size() > 0) g = idx;
    end
    if (g >= 0) m_rr = (g + 1) % 3;
`endif
    if (g >= 0) begin
      m_out = mq[g].pop_front();
      m_src = g;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i] && rd[i]) begin
        e.rob   = req_rob_pos[i*4 +: 4];
        e.value = req_value[i*32 +: 32];
        e.pc    = req_pc[i*32 +: 32];
        mq[i].push_back(e);
        m_acc[i] = 1'b1;
      end
    end
  endtask

  task automatic drive();
    req_valid = offer;
    for (int i = 0; i < 3; i++) begin
      req_rob_pos[i*4 +: 4] = off_ent[i].rob;
      req_value[i*32 +: 32] = off_ent[i].value;
      req_pc[i*32 +: 32]    = off_ent[i].pc;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic refill();
    for (int i = 0; i < 3; i++) if (m_acc[i]) off_ent[i] = new_ent();
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; offer = '0;
    for (int i = 0; i < 3; i++) off_ent[i] = new_ent();
    drive();
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if ({cdb_valid, cdb_rob_pos, cdb_value, cdb_pc, cdb_src} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got v=%0b rob=%0d val=%h pc=%h src=%0d want all zero",
                        cdb_valid, cdb_rob_pos, cdb_value, cdb_pc, cdb_src);
    end
    n_cmp++;
    if (req_ready !== 3'b000) begin
      n_bad++; $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    rst_in = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (req_ready !== 3'b111) begin
      n_bad++; $display("FAIL reset_release_ready: got %b want 111", req_ready);
    end
  endtask

  task automatic test_single_latency();
    offer = 3'b001;
    off_ent[0] = '{rob: 4'd5, value: 32'hDEADBEEF, pc: 32'h0000_1000};
    drive();
    tick();
    offer = '0; drive();
    n_cmp++;
    if (cdb_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_early: got valid=%0b want 0", cdb_valid);
    end
    tick();
    n_cmp++;
    if ({cdb_valid, cdb_rob_pos, cdb_value, cdb_pc, cdb_src} !== {1'b1, 4'd5, 32'hDEADBEEF, 32'h0000_1000, 2'd0}) begin
      n_bad++; $display("FAIL single_result: got v=%0b rob=%0d val=%h pc=%h src=%0d want v=1 rob=5 val=deadbeef pc=00001000 src=0",
                        cdb_valid, cdb_rob_pos, cdb_value, cdb_pc, cdb_src);
    end
    tick();
    n_cmp++;
    if (cdb_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_pulse: got valid=%0b want 0", cdb_valid);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 3; i++) off_ent[i] = new_ent();
    for (int c = 0; c < 12; c++) begin
      offer = (c < 4) ? 3'b111 : 3'b000;
      drive();
      tick();
      refill();
      n_cmp++;
      if (cdb_valid !== m_valid) begin
        n_bad++; $display("FAIL rr_valid c=%0d: got %0b want %0b", c, cdb_valid, m_valid);
      end else if (m_valid) begin
        n_cmp++;
        if ({cdb_src, cdb_rob_pos, cdb_value, cdb_pc} !== {m_src[1:0], m_out}) begin
          n_bad++; $display("FAIL rr_entry c=%0d: got src=%0d rob=%0d val=%h want src=%0d rob=%0d val=%h",
                            c, cdb_src, cdb_rob_pos, cdb_value, m_src, m_out.rob, m_out.value);
        end
      end
    end
  endtask

  task automatic test_full_buffer();
    for (int c = 0; c < 10; c++) begin
      offer = 3'b111; drive(); #1;
      n_cmp++;
      if (req_ready !== m_ready()) begin
        n_bad++; $display("FAIL full_ready c=%0d: got %b want %b", c, req_ready, m_ready());
      end
      if (mq[2].size() == 2) begin
        n_cmp++;
        if (req_ready[2] !== 1'b0) begin
          n_bad++; $display("FAIL full_slb_ready c=%0d: got %0b want 0", c, req_ready[2]);
        end
      end
      tick();
      refill();
      n_cmp++;
      if (cdb_valid !== m_valid || (m_valid && {cdb_src, cdb_rob_pos, cdb_value} !== {m_src[1:0], m_out.rob, m_out.value})) begin
        n_bad++; $display("FAIL full_out c=%0d: got v=%0b src=%0d rob=%0d want v=%0b src=%0d rob=%0d",
                          c, cdb_valid, cdb_src, cdb_rob_pos, m_valid, m_src, m_out.rob);
      end
    end
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(); #1;
      n_cmp++;
      if (req_ready !== 3'b000) begin
        n_bad++; $display("FAIL full_frozen_ready c=%0d: got %b want 000", c, req_ready);
      end
      tick();
    end
    rdy_in = 1'b1; offer = '0; drive();
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== m_valid || (m_valid && {cdb_src, cdb_rob_pos, cdb_pc} !== {m_src[1:0], m_out.rob, m_out.pc})) begin
        n_bad++; $display("FAIL full_drain c=%0d: got v=%0b src=%0d rob=%0d want v=%0b src=%0d rob=%0d",
                          c, cdb_valid, cdb_src, cdb_rob_pos, m_valid, m_src, m_out.rob);
      end
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 6; c++) begin
      offer = 3'b111; drive(); tick(); refill();
    end
    flush_in = 1'b1; drive(); #1;
    n_cmp++;
    if (req_ready !== 3'b000) begin
      n_bad++; $display("FAIL flush_ready_low: got %b want 000", req_ready);
    end
    tick();
    flush_in = 1'b0; offer = '0; drive(); #1;
    n_cmp++;
    if (cdb_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_valid: got %0b want 0", cdb_valid);
    end
    n_cmp++;
    if (req_ready !== 3'b111) begin
      n_bad++; $display("FAIL flush_ready: got %b want 111", req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== 1'b0) begin
        n_bad++; $display("FAIL flush_drop c=%0d: got valid=%0b want 0", c, cdb_valid);
      end
    end
    for (int i = 0; i < 3; i++) off_ent[i] = new_ent();
    offer = 3'b111; drive(); tick();
    offer = '0; drive(); tick();
    n_cmp++;
`ifdef CDB_FIXED_PRIO_EN
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_rob_pos !== off_ent[2].rob) begin
      n_bad++; $display("FAIL flush_first_grant: got v=%0b src=%0d rob=%0d want v=1 src=2 rob=%0d",
                        cdb_valid, cdb_src, cdb_rob_pos, off_ent[2].rob);
    end
`else
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_rob_pos !== off_ent[0].rob) begin
      n_bad++; $display("FAIL flush_first_grant: got v=%0b src=%0d rob=%0d want v=1 src=0 rob=%0d",
                        cdb_valid, cdb_src, cdb_rob_pos, off_ent[0].rob);
    end
`endif
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== m_valid || (m_valid && {cdb_src, cdb_rob_pos, cdb_value} !== {m_src[1:0], m_out.rob, m_out.value})) begin
        n_bad++; $display("FAIL flush_after c=%0d: got v=%0b src=%0d want v=%0b src=%0d", c, cdb_valid, cdb_src, m_valid, m_src);
      end
    end
  endtask

  task automatic test_stall();
    off_ent[0] = '{rob: 4'd7, value: 32'h0000_0777, pc: 32'h0000_0070};
    offer = 3'b001; drive(); tick();
    off_ent[1] = '{rob: 4'd9, value: 32'h0000_0999, pc: 32'h0000_0090};
    offer = 3'b010; drive(); tick();
    offer = '0; drive();
    n_cmp++;
    if ({cdb_valid, cdb_rob_pos, cdb_src} !== {1'b1, 4'd7, 2'd0}) begin
      n_bad++; $display("FAIL stall_setup: got v=%0b rob=%0d src=%0d want v=1 rob=7 src=0", cdb_valid, cdb_rob_pos, cdb_src);
    end
    rdy_in = 1'b0;
    off_ent[2] = new_ent();
    offer = 3'b100;
    for (int c = 0; c < 5; c++) begin
      flush_in = (c == 2);
      drive(); #1;
      n_cmp++;
      if (req_ready !== 3'b000) begin
        n_bad++; $display("FAIL stall_ready c=%0d: got %b want 000", c, req_ready);
      end
      tick();
      n_cmp++;
      if ({cdb_valid, cdb_rob_pos, cdb_value, cdb_src} !== {1'b1, 4'd7, 32'h0000_0777, 2'd0}) begin
        n_bad++; $display("FAIL stall_hold c=%0d: got v=%0b rob=%0d val=%h src=%0d want v=1 rob=7 val=00000777 src=0",
                          c, cdb_valid, cdb_rob_pos, cdb_value, cdb_src);
      end
    end
    rdy_in = 1'b1; flush_in = 1'b0; drive(); tick();
    offer = '0; drive();
    n_cmp++;
    if ({cdb_valid, cdb_rob_pos, cdb_src} !== {1'b1, 4'd9, 2'd1}) begin
      n_bad++; $display("FAIL stall_resume: got v=%0b rob=%0d src=%0d want v=1 rob=9 src=1", cdb_valid, cdb_rob_pos, cdb_src);
    end
    tick();
    n_cmp++;
    if ({cdb_valid, cdb_rob_pos, cdb_src} !== {1'b1, off_ent[2].rob, 2'd2}) begin
      n_bad++; $display("FAIL stall_slb: got v=%0b rob=%0d src=%0d want v=1 rob=%0d src=2", cdb_valid, cdb_rob_pos, cdb_src, off_ent[2].rob);
    end
    tick();
    off_ent[0] = new_ent(); off_ent[2] = new_ent();
    offer = 3'b101; drive(); tick();
    offer = '0; drive();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== m_valid || (m_valid && {cdb_src, cdb_rob_pos, cdb_value} !== {m_src[1:0], m_out.rob, m_out.value})) begin
        n_bad++; $display("FAIL stall_pair c=%0d: got v=%0b src=%0d want v=%0b src=%0d", c, cdb_valid, cdb_src, m_valid, m_src);
      end
`ifdef CDB_FIXED_PRIO_EN
      if (c == 0) begin
        n_cmp++;
        if (cdb_src !== 2'd2) begin
          n_bad++; $display("FAIL fixed_prio_first: got src=%0d want 2", cdb_src);
        end
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) off_ent[i] = new_ent();
    for (int c = 0; c < 3; c++) begin
      offer = 3'b111; drive(); tick(); refill();
    end
    #2;
    rst_in = 1'b0;
    #1;
    n_cmp++;
    if (cdb_valid !== 1'b0 || req_ready !== 3'b000) begin
      n_bad++; $display("FAIL midreset: got valid=%0b ready=%b want valid=0 ready=000", cdb_valid, req_ready);
    end
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1; offer = '0; drive(); #1;
    n_cmp++;
    if (req_ready !== 3'b111) begin
      n_bad++; $display("FAIL midreset_release: got ready=%b want 111", req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== 1'b0) begin
        n_bad++; $display("FAIL midreset_replay c=%0d: got valid=%0b want 0", c, cdb_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) off_ent[i] = new_ent();
    offer = '0;
    for (int c = 0; c < 600; c++) begin
      rdy_in   = ($urandom_range(0, 7) != 0);
      flush_in = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < 3; i++) if (!offer[i]) offer[i] = 1'($urandom_range(0, 1));
      drive(); #1;
      n_cmp++;
      if (req_ready !== m_ready()) begin
        n_bad++; $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, m_ready());
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        if (m_acc[i]) begin
          off_ent[i] = new_ent();
          offer[i] = 1'b0;
        end
      end
      n_cmp++;
      if (cdb_valid !== m_valid || (m_valid && {cdb_src, cdb_rob_pos, cdb_value, cdb_pc} !== {m_src[1:0], m_out})) begin
        n_bad++; $display("FAIL rand_out c=%0d: got v=%0b src=%0d rob=%0d val=%h want v=%0b src=%0d rob=%0d val=%h",
                          c, cdb_valid, cdb_src, cdb_rob_pos, cdb_value, m_valid, m_src, m_out.rob, m_out.value);
      end
    end
    rdy_in = 1'b1; flush_in = 1'b0; offer = '0; drive();
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid !== m_valid || (m_valid && {cdb_src, cdb_rob_pos} !== {m_src[1:0], m_out.rob})) begin
        n_bad++; $display("FAIL rand_drain c=%0d: got v=%0b src=%0d want v=%0b src=%0d", c, cdb_valid, cdb_src, m_valid, m_src);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_latency();
    test_round_robin();
    test_full_buffer();
    test_flush();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
